// File: rtl/led_matrix_scan_ctrl.sv
// led_matrix_scan_ctrl: HUB75 row/latch/blank sequencer with BCM bit planes and dead time around the latch.
module led_matrix_scan_ctrl #(
  parameter int ROWS       = 32,
  parameter int ROW_W      = 5,
  parameter int PWM_BITS   = 7,
  parameter int PLANE_W    = 3,
  parameter int BASE_ON    = 8,
  parameter int BLANK_DEAD = 4,
  parameter int LATCH_DEAD = 2
) (
  input  logic               clk_25MHz,
  input  logic               rst,
  input  logic               enable,
  output logic [ROW_W-1:0]   row_addr,
  output logic               blank,
  output logic               latch,
  output logic               next_line_begin,
  input  logic               next_line_done,
  output logic [ROW_W-1:0]   next_line_addr,
  output logic [PLANE_W-1:0] next_line_plane,
  output logic               frame_start
);
  localparam int TW = $clog2(BASE_ON) + PWM_BITS;
  localparam int DW = $clog2(BLANK_DEAD + LATCH_DEAD + 2);
  typedef enum logic [2:0] {IDLE, SHIFT, PRE_DEAD, LATCH, POST_DEAD, UNBLANK} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [DW-1:0] dead;
  logic [PLANE_W-1:0] plane;
  logic done_flag, last_plane, last_row, to_latch;
  assign last_plane = next_line_plane == PLANE_W'(PWM_BITS - 1);
  assign last_row = next_line_addr == ROW_W'(ROWS - 1);
  // Cycle whose edge raises latch and moves the shifted line onto the panel.
  assign to_latch = (state == PRE_DEAD && dead == '0) ||
                    (state == SHIFT && timer == '0 && done_flag && BLANK_DEAD == 0);
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      blank <= 1'b1;
      latch <= 1'b0;
      row_addr <= '0;
      next_line_addr <= '0;
      next_line_plane <= '0;
      next_line_begin <= 1'b0;
      frame_start <= 1'b0;
      timer <= '0;
      dead <= '0;
      plane <= '0;
      done_flag <= 1'b0;
    end else begin
      next_line_begin <= 1'b0;
      frame_start <= 1'b0;
      latch <= to_latch;
      done_flag <= !next_line_begin && (done_flag || next_line_done);
      if (to_latch) begin
        row_addr <= next_line_addr;
        plane <= next_line_plane;
      end
      case (state)
        IDLE: begin
          blank <= 1'b1;
          if (enable) begin
            next_line_begin <= 1'b1;
            frame_start <= 1'b1;
            done_flag <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
            blank <= timer == TW'(1);
          end else if (done_flag) begin
            state <= BLANK_DEAD == 0 ? LATCH : PRE_DEAD;
            dead <= DW'(BLANK_DEAD - 1);
          end
        end
        PRE_DEAD: begin
          dead <= dead - 1'b1;
          if (dead == '0) state <= LATCH;
        end
        LATCH: begin
          state <= LATCH_DEAD == 0 ? UNBLANK : POST_DEAD;
          dead <= DW'(LATCH_DEAD - 1);
        end
        POST_DEAD: begin
          dead <= dead - 1'b1;
          if (dead == '0) state <= UNBLANK;
        end
        UNBLANK: begin
          if (enable) begin
            blank <= 1'b0;
            timer <= TW'(BASE_ON) << plane;
            next_line_plane <= last_plane ? '0 : next_line_plane + 1'b1;
            if (last_plane) next_line_addr <= last_row ? '0 : next_line_addr + 1'b1;
            next_line_begin <= 1'b1;
            frame_start <= last_plane && last_row;
            done_flag <= 1'b0;
            state <= SHIFT;
          end else begin
            next_line_addr <= '0;
            next_line_plane <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// tb_led_matrix_scan_ctrl: directed checks of blank/latch timing, BCM widths, pointer sequencing and reset.
module tb_led_matrix_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, done = 1'b0;
  logic [1:0] row_addr, next_line_addr, next_line_plane;
  logic blank, latch, next_line_begin, frame_start;
  int errors = 0, checks = 0, done_delay = 1;

  led_matrix_scan_ctrl #(.ROWS(4), .ROW_W(2), .PWM_BITS(3), .PLANE_W(2), .BASE_ON(4),
                         .BLANK_DEAD(2), .LATCH_DEAD(1)) dut (
    .clk_25MHz(clk), .rst(rst), .enable(enable), .row_addr(row_addr), .blank(blank),
    .latch(latch), .next_line_begin(next_line_begin), .next_line_done(done),
    .next_line_addr(next_line_addr), .next_line_plane(next_line_plane), .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // Line shifter stand-in: answers each begin with a done pulse done_delay cycles later.
  initial forever begin
    @(negedge clk);
    if (next_line_begin) begin
      repeat (done_delay) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end
  end

  function automatic logic sig(input int w);
    return w == 0 ? blank : w == 1 ? latch : w == 2 ? next_line_begin : frame_start;
  endfunction

  task automatic wait_sig(input int w, input logic v, input int maxc, output int n);
    n = 0;
    while (sig(w) !== v) begin
      if (n == maxc) begin
        n = -1;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic measure(input logic v, output int n);
    n = 0;
    while (blank === v && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({blank, latch, next_line_begin, frame_start} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 1000", {blank, latch, next_line_begin, frame_start});
    end
    checks++;
    if ({row_addr, next_line_addr, next_line_plane} !== 6'b0) begin
      errors++;
      $display("FAIL reset_addr: got %b expected 000000", {row_addr, next_line_addr, next_line_plane});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({blank, latch, next_line_begin, frame_start} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_no_enable: got %b expected 1000", {blank, latch, next_line_begin, frame_start});
    end
  endtask

  task automatic test_first_line;
    int n;
    done_delay = 5;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({next_line_begin, frame_start, blank} !== 3'b111) begin
      errors++;
      $display("FAIL first_begin: got %b expected 111", {next_line_begin, frame_start, blank});
    end
    checks++;
    if ({next_line_addr, next_line_plane} !== 4'b0000) begin
      errors++;
      $display("FAIL first_ptr: got %b expected 0000", {next_line_addr, next_line_plane});
    end
    wait_sig(1, 1'b1, 40, n);
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL first_latch_delay: got %0d expected 9", n);
    end
    checks++;
    if (blank !== 1'b1 || row_addr !== 2'd0) begin
      errors++;
      $display("FAIL first_latch_state: got blank=%b row=%0d expected blank=1 row=0", blank, row_addr);
    end
    done_delay = 1;
    @(negedge clk);
    checks++;
    if (latch !== 1'b0) begin
      errors++;
      $display("FAIL latch_width: got %b expected 0", latch);
    end
    wait_sig(0, 1'b0, 10, n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL post_dead: got %0d expected 2", n);
    end
    checks++;
    if ({next_line_begin, frame_start, next_line_addr, next_line_plane} !== 6'b100001) begin
      errors++;
      $display("FAIL begin_0_1: got %b expected 100001",
               {next_line_begin, frame_start, next_line_addr, next_line_plane});
    end
  endtask

  task automatic test_instant_done;
    int n, p;
    measure(1'b0, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL on_width_p0: got %0d expected 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      p = (k + 1) % 3;
      measure(1'b1, n);
      checks++;
      if (n !== 6) begin
        errors++;
        $display("FAIL blank_window k=%0d: got %0d expected 6", k, n);
      end
      checks++;
      if (next_line_begin !== 1'b1) begin
        errors++;
        $display("FAIL begin_at_unblank k=%0d: got %b expected 1", k, next_line_begin);
      end
      measure(1'b0, n);
      checks++;
      if (n !== (4 << p)) begin
        errors++;
        $display("FAIL on_width plane=%0d: got %0d expected %0d", p, n, 4 << p);
      end
    end
  endtask

  task automatic test_late_done;
    int n;
    measure(1'b1, n);
    measure(1'b0, n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL late_pre_on: got %0d expected 16", n);
    end
    done_delay = 30;
    measure(1'b1, n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL late_pre_blank: got %0d expected 6", n);
    end
    measure(1'b0, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL late_on_width: got %0d expected 4", n);
    end
    done_delay = 1;
    measure(1'b1, n);
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL late_blank_window: got %0d expected 33", n);
    end
    measure(1'b0, n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL late_next_on: got %0d expected 8", n);
    end
  endtask

  task automatic test_frame;
    int n, m, total;
    logic [1:0] er, ep, dr;
    wait_sig(3, 1'b1, 400, n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL frame_start_seen: got timeout expected pulse");
    end
    total = 0;
    for (int i = 1; i <= 12; i++) begin
      wait_sig(2, 1'b0, 5, n);
      total += n;
      wait_sig(2, 1'b1, 60, m);
      total += m;
      er = 2'((i / 3) % 4);
      ep = 2'(i % 3);
      dr = 2'((i - 1) / 3);
      checks++;
      if ({next_line_addr, next_line_plane} !== {er, ep}) begin
        errors++;
        $display("FAIL ptr i=%0d: got %0d,%0d expected %0d,%0d", i, next_line_addr, next_line_plane, er, ep);
      end
      checks++;
      if (row_addr !== dr) begin
        errors++;
        $display("FAIL row_addr i=%0d: got %0d expected %0d", i, row_addr, dr);
      end
      checks++;
      if (frame_start !== (i == 12)) begin
        errors++;
        $display("FAIL frame_start i=%0d: got %b expected %b", i, frame_start, i == 12);
      end
    end
    checks++;
    if (total !== 184) begin
      errors++;
      $display("FAIL frame_period: got %0d expected 184", total);
    end
  endtask

  task automatic test_disable;
    int n, bad;
    wait_sig(2, 1'b0, 5, n);
    wait_sig(2, 1'b1, 60, n);
    wait_sig(0, 1'b1, 20, n);
    @(negedge clk);
    enable = 1'b0;
    wait_sig(1, 1'b1, 10, n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL disable_latch: got %0d expected 2", n);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (blank !== 1'b1 || next_line_begin !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL disable_idle: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if ({next_line_addr, next_line_plane} !== 4'b0000) begin
      errors++;
      $display("FAIL disable_ptr: got %b expected 0000", {next_line_addr, next_line_plane});
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({next_line_begin, frame_start, next_line_addr, next_line_plane} !== 6'b110000) begin
      errors++;
      $display("FAIL reenable: got %b expected 110000",
               {next_line_begin, frame_start, next_line_addr, next_line_plane});
    end
  endtask

  task automatic test_rst_latch;
    int n;
    wait_sig(1, 1'b1, 40, n);
    rst = 1'b1;
    #1;
    checks++;
    if (n < 0 || latch !== 1'b0 || blank !== 1'b1) begin
      errors++;
      $display("FAIL async_rst: got wait=%0d latch=%b blank=%b expected latch=0 blank=1", n, latch, blank);
    end
    @(negedge clk);
    checks++;
    if ({next_line_begin, frame_start, row_addr, next_line_addr, next_line_plane} !== 8'b0) begin
      errors++;
      $display("FAIL rst_hold: got %b expected 00000000",
               {next_line_begin, frame_start, row_addr, next_line_addr, next_line_plane});
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_instant_done();
    test_late_done();
    test_frame();
    test_disable();
    test_rst_latch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_matrix_scan_ctrl.md
# led_matrix_scan_ctrl

Parametrised HUB75 scan controller: the next generation of our row/latch/blank sequencer. It drives row addressing and the blank/latch strobes, and requests line shifts from the line-shifter block. It adds binary-code-modulated (BCM) bit planes with per-plane on-time, configurable dead time around the latch, an enable input, a frame marker and an asynchronous reset. It sits between the frame-buffer line shifter (next_line_* handshake) and the panel connector pins.

## Interface
- ROWS, 32: scan rows per frame (≥2); row index wraps ROWS-1→0.
- ROW_W, 5: row address width; requires 2**ROW_W ≥ ROWS.
- PWM_BITS, 7: number of bit planes (≥1).
- PLANE_W, 3: plane index width; requires 2**PLANE_W ≥ PWM_BITS.
- BASE_ON, 8: unblanked cycles for plane 0 (≥1); plane p gets BASE_ON<<p.
- BLANK_DEAD, 4: cycles between blank rising and latch rising (≥0).
- LATCH_DEAD, 2: cycles between latch falling and blank falling (≥0).

Ports:
- clk_25MHz  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request.
- row_addr  out  ROW_W  row currently displayed on the panel.
- blank  out  1  panel output-enable, active-high blank.
- latch  out  1  panel latch strobe.
- next_line_begin  out  1  one-cycle pulse: shifter starts loading (next_line_addr, next_line_plane).
- next_line_done  in  1  one-cycle pulse from shifter: requested line fully shifted.
- next_line_addr  out  ROW_W  row being shifted.
- next_line_plane  out  PLANE_W  bit plane being shifted.
- frame_start  out  1  one-cycle pulse, coincident with next_line_begin for (row 0, plane 0).

## Operation
- Reset values: blank=1, latch=0, row_addr=0, next_line_addr=0, next_line_plane=0, next_line_begin=0, frame_start=0, on-timer=0, done flag=0, state IDLE. Reset asserted mid-operation forces all of these immediately.
- States: IDLE, SHIFT, PRE_DEAD, LATCH, POST_DEAD, UNBLANK.
- IDLE: blank=1. With enable=1: pulse next_line_begin and frame_start for (0,0), then go to SHIFT.
- SHIFT: the on-timer counts down to 0 while blank=0. When the on-timer reaches 0, blank<=1 at once, even if the shift is not done, so no plane is over-exposed. A next_line_done pulse sets a sticky done flag. The flag ignores done in the same cycle as next_line_begin and clears on each begin. When the done flag=1 and the on-timer=0, go to PRE_DEAD with blank=1.
- PRE_DEAD: hold for BLANK_DEAD cycles, then go to LATCH.
- LATCH: latch=1 for exactly 1 cycle. row_addr<=next_line_addr and the displayed plane<=next_line_plane, so row_addr changes on the latch-rising edge. Then go to POST_DEAD.
- POST_DEAD: latch=0; hold for LATCH_DEAD cycles, then go to UNBLANK.
- UNBLANK, when enable=1:
  - blank<=0; on-timer<=BASE_ON<<displayed plane.
  - Advance the shift pointer: plane+1. After plane PWM_BITS-1, plane goes to 0 and row goes +1. After row ROWS-1, row goes to 0.
  - Pulse next_line_begin with the new pointer; pulse frame_start if the new pointer is (0,0).
  - Go to SHIFT.
- UNBLANK with enable=0: blank stays 1, no begin is issued, pointers reset to (0,0), go to IDLE. Enable is sampled only in IDLE and UNBLANK, so a latch in progress always completes.
- Width: the on-timer is clog2(BASE_ON)+PWM_BITS bits wide; no overflow at the largest plane.

## Timing
- enable high in IDLE → next_line_begin 1 cycle later.
- Minimum blank window per plane (shift already done when the timer expires): BLANK_DEAD+LATCH_DEAD+3 cycles.
  - latch rises BLANK_DEAD+1 cycles after blank rises.
  - blank falls LATCH_DEAD+1 cycles after latch falls.
- Unblanked time per plane: exactly BASE_ON<<p cycles. A late next_line_done only lengthens the blank time.
- Each next_line_begin follows blank falling in the same cycle; the shift overlaps display.
- Frame period with fast shifts: ROWS × (BASE_ON×(2**PWM_BITS−1) + PWM_BITS×(BLANK_DEAD+LATCH_DEAD+3)) cycles.

## Test plan
Parameters for all cases: ROWS=4, PWM_BITS=3, BASE_ON=4, BLANK_DEAD=2, LATCH_DEAD=1.

- Reset, then enable=1 → all outputs at reset values during reset; next_line_begin+frame_start 1 cycle after enable, addr=0, plane=0; blank stays 1.
- next_line_done 5 cycles after begin → blank rises after done; latch high for 1 cycle, 3 cycles after blank rises; row_addr=0 after latch; blank falls 2 cycles after latch falls; begin (0,1) in the same cycle blank falls.
- Instant done each plane → blank-low widths 4, 8, 16 cycles for planes 0, 1, 2; blank-high windows 6 cycles each.
- Done delayed 30 cycles on plane 0 → blank rises exactly 4 cycles after unblank and stays high until done+PRE_DEAD; no extra unblanked cycles.
- Run 12 planes → row_addr sequence 0,1,2,3; the pointer after (3,2) is (0,0) with frame_start pulsing once; the frame period matches the formula.
- Drop enable mid-PRE_DEAD → latch still pulses and blank stays 1, then IDLE; re-enable restarts at (0,0) with frame_start. Assert rst while latch=1 → latch=0, blank=1 immediately.
